vga_plot_sink: RTL and testbench

Receiving end of the pixel-plot interface driven by vga_demo, with the same VGA_X/VGA_Y/VGA_COLOR/plot semantics. It accepts plot writes into a 4-entry FIFO and commits them to a 160x120, 3-bit framebuffer. A raster reader streams the framebuffer back out over a valid/ready interface. It is the bench-side and display-side model that renders what an object drawer plots.

---
 rtl/vga_plot_sink.sv | 194 +++++++++++++++++++
 tb/tb_vga_plot_sink.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_plot_sink.sv
// vga_plot_sink: receiving end of a pixel-plot interface.
//   Plot writes are queued in a small FIFO and committed to a 160x120, 3-bit
//   framebuffer. After reset the framebuffer is cleared one address per cycle.
//   A raster reader then streams the framebuffer out over valid/ready.
// Ports:
//   CLOCK_50, Resetn         clock, asynchronous active-low reset
//   VGA_X, VGA_Y, VGA_COLOR  plot coordinate and colour
//   plot                     write strobe, one pixel per high cycle
//   busy                     clearing, or FIFO full with no pop this cycle
//   drop                     sticky flag, a plot was discarded
//   pix_x, pix_y, pix_color  scanned coordinate and framebuffer contents
//   pix_valid, pix_ready     scan output handshake
//   frame_start              presented pixel is (0,0)
module vga_plot_sink #(
  parameter int unsigned XRES       = 160,
  parameter int unsigned YRES       = 120,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       CLOCK_50,
  input  logic       Resetn,
  input  logic [7:0] VGA_X,
  input  logic [6:0] VGA_Y,
  input  logic [2:0] VGA_COLOR,
  input  logic       plot,
  output logic       busy,
  output logic       drop,
  output logic [7:0] pix_x,
  output logic [6:0] pix_y,
  output logic [2:0] pix_color,
  output logic       pix_valid,
  input  logic       pix_ready,
  output logic       frame_start
);

  localparam int unsigned ADDR_W = 15;
  localparam int unsigned NPIX   = XRES * YRES;
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;

  typedef enum logic {CTRL_CLEAR, CTRL_RUN} ctrl_t;
  typedef enum logic {SCAN_FETCH, SCAN_PRESENT} scan_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [2:0]        color;
  } plot_t;

  ctrl_t             r_ctrl;
  logic [ADDR_W-1:0] r_clr_addr;
  plot_t             r_fifo [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_drop;
  logic [2:0]        r_mem [NPIX];
  logic [2:0]        r_rd_data;
  scan_t             r_scan;
  logic [7:0]        r_pix_x;
  logic [6:0]        r_pix_y;
  logic              r_pix_valid;
  logic              r_frame_start;

  logic              w_run;
  logic              w_pop;
  logic              w_full;
  logic              w_busy;
  logic              w_in_range;
  logic              w_push;
  logic [ADDR_W-1:0] w_plot_addr;
  plot_t             w_head;
  logic              w_we;
  logic [ADDR_W-1:0] w_wa;
  logic [2:0]        w_wd;
  logic              w_fetch;
  logic [ADDR_W-1:0] w_rd_addr;

  // Plot acceptance and drain control
  assign w_run       = (r_ctrl == CTRL_RUN);
  assign w_pop       = w_run && (r_count != '0);
  assign w_full      = (r_count == CNT_W'(FIFO_DEPTH));
  // A same-cycle pop frees a slot, so a full FIFO only blocks when nothing drains
  assign w_busy      = !w_run || (w_full && !w_pop);
  assign w_in_range  = (32'(VGA_X) < XRES) && (32'(VGA_Y) < YRES);
  assign w_push      = plot && !w_busy && w_in_range;
  assign w_plot_addr = ADDR_W'(VGA_Y) * ADDR_W'(XRES) + ADDR_W'(VGA_X);
  assign w_head      = r_fifo[r_rd_ptr];

  // Framebuffer write port: zero-fill while clearing, FIFO head while running
  assign w_we = !w_run || w_pop;
  assign w_wa = w_run ? w_head.addr : r_clr_addr;
  assign w_wd = w_run ? w_head.color : 3'd0;

  assign w_fetch   = w_run && (r_scan == SCAN_FETCH);
  assign w_rd_addr = ADDR_W'(r_pix_y) * ADDR_W'(XRES) + ADDR_W'(r_pix_x);

  // Control: clear sweep, then run
  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      r_ctrl     <= CTRL_CLEAR;
      r_clr_addr <= '0;
    end else begin
      case (r_ctrl)
        CTRL_CLEAR: begin
          if (r_clr_addr == ADDR_W'(NPIX - 1)) begin
            r_ctrl <= CTRL_RUN;
          end else begin
            r_clr_addr <= r_clr_addr + ADDR_W'(1);
          end
        end
        default: r_ctrl <= CTRL_RUN;
      endcase
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO storage
  always_ff @(posedge CLOCK_50) begin
    if (w_push) r_fifo[r_wr_ptr] <= '{addr: w_plot_addr, color: VGA_COLOR};
  end

  // Sticky discard flag
  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      r_drop <= 1'b0;
    end else if (plot && !w_push) begin
      r_drop <= 1'b1;
    end
  end

  // Framebuffer: one write, one registered read (read-before-write)
  always_ff @(posedge CLOCK_50) begin
    if (w_we)    r_mem[w_wa] <= w_wd;
    if (w_fetch) r_rd_data   <= r_mem[w_rd_addr];
  end

  // Raster scan reader
  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      r_scan        <= SCAN_FETCH;
      r_pix_x       <= '0;
      r_pix_y       <= '0;
      r_pix_valid   <= 1'b0;
      r_frame_start <= 1'b0;
    end else if (w_run) begin
      case (r_scan)
        SCAN_FETCH: begin
          r_pix_valid   <= 1'b1;
          r_frame_start <= (r_pix_x == '0) && (r_pix_y == '0);
          r_scan        <= SCAN_PRESENT;
        end
        default: begin
          if (pix_ready) begin
            r_pix_valid   <= 1'b0;
            r_frame_start <= 1'b0;
            r_scan        <= SCAN_FETCH;
            if (r_pix_x == 8'(XRES - 1)) begin
              r_pix_x <= '0;
              if (r_pix_y == 7'(YRES - 1)) r_pix_y <= '0;
              else                         r_pix_y <= r_pix_y + 7'd1;
            end else begin
              r_pix_x <= r_pix_x + 8'd1;
            end
          end
        end
      endcase
    end
  end

  assign busy        = w_busy;
  assign drop        = r_drop;
  assign pix_x       = r_pix_x;
  assign pix_y       = r_pix_y;
  // Read data register has no reset; gating by valid gives 0 out of reset
  assign pix_color   = r_pix_valid ? r_rd_data : 3'd0;
  assign pix_valid   = r_pix_valid;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_plot_sink.sv
module tb_vga_plot_sink;

  logic       CLOCK_50;
  logic       Resetn;
  logic [7:0] VGA_X;
  logic [6:0] VGA_Y;
  logic [2:0] VGA_COLOR;
  logic       plot;
  logic       busy;
  logic       drop;
  logic [7:0] pix_x;
  logic [6:0] pix_y;
  logic [2:0] pix_color;
  logic       pix_valid;
  logic       pix_ready;
  logic       frame_start;

  int tests = 0;
  int fails = 0;

  logic [2:0] exp_fb [0:19199];
  logic [2:0] obs_fb [0:19199];

  vga_plot_sink dut (
    .CLOCK_50   (CLOCK_50),
    .Resetn     (Resetn),
    .VGA_X      (VGA_X),
    .VGA_Y      (VGA_Y),
    .VGA_COLOR  (VGA_COLOR),
    .plot       (plot),
    .busy       (busy),
    .drop       (drop),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .pix_color  (pix_color),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .frame_start(frame_start)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic do_plot(input logic [7:0] x, input logic [6:0] y, input logic [2:0] c);
    VGA_X = x; VGA_Y = y; VGA_COLOR = c; plot = 1'b1;
    tick();
    plot = 1'b0;
  endtask

  task automatic wait_valid(output bit ok);
    int n;
    n = 0;
    while (pix_valid !== 1'b1 && n < 16) begin
      tick();
      n++;
    end
    ok = (pix_valid === 1'b1);
  endtask

  task automatic test_reset();
    Resetn = 1'b0; plot = 1'b0; pix_ready = 1'b0;
    VGA_X = '0; VGA_Y = '0; VGA_COLOR = '0;
    repeat (3) tick();
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL reset_busy: got %b, expected 1", busy); end
    tests++; if (drop !== 1'b0) begin fails++; $display("FAIL reset_drop: got %b, expected 0", drop); end
    tests++; if (pix_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b, expected 0", pix_valid); end
    tests++; if (pix_x !== 8'd0 || pix_y !== 7'd0) begin fails++; $display("FAIL reset_xy: got (%0d,%0d), expected (0,0)", pix_x, pix_y); end
    tests++; if (pix_color !== 3'd0) begin fails++; $display("FAIL reset_color: got %0d, expected 0", pix_color); end
    tests++; if (frame_start !== 1'b0) begin fails++; $display("FAIL reset_fs: got %b, expected 0", frame_start); end
  endtask

  task automatic test_clear();
    int n;
    bit ok;
    Resetn = 1'b1;
    n = 0;
    while (busy === 1'b1 && n < 20000) begin
      tick();
      n++;
    end
    tests++; if (n != 19200) begin fails++; $display("FAIL clear_len: got %0d busy cycles, expected 19200", n); end
    wait_valid(ok);
    tests++; if (!ok) begin fails++; $display("FAIL first_valid: got timeout, expected pix_valid=1"); end
    tests++; if (pix_x !== 8'd0 || pix_y !== 7'd0) begin fails++; $display("FAIL first_xy: got (%0d,%0d), expected (0,0)", pix_x, pix_y); end
    tests++; if (pix_color !== 3'd0) begin fails++; $display("FAIL first_color: got %0d, expected 0", pix_color); end
    tests++; if (frame_start !== 1'b1) begin fails++; $display("FAIL first_fs: got %b, expected 1", frame_start); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL run_busy: got %b, expected 0", busy); end
  endtask

  task automatic test_plot();
    do_plot(8'h48, 7'h48, 3'b101);
    exp_fb[11592] = 3'd5;
    tests++; if (drop !== 1'b0) begin fails++; $display("FAIL plot_drop: got %b, expected 0", drop); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL plot_busy: got %b, expected 0", busy); end
  endtask

  task automatic test_out_of_range();
    do_plot(8'd160, 7'd0, 3'd7);
    tests++; if (drop !== 1'b1) begin fails++; $display("FAIL oor_x_drop: got %b, expected 1", drop); end
    do_plot(8'd0, 7'd120, 3'd7);
    tests++; if (drop !== 1'b1) begin fails++; $display("FAIL oor_y_drop: got %b, expected 1", drop); end
    do_plot(8'd5, 7'd0, 3'd2);
    exp_fb[5] = 3'd2;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL legal_after_drop_busy: got %b, expected 0", busy); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) begin
      VGA_X = 8'(10 + i); VGA_Y = 7'd2; VGA_COLOR = 3'(i + 1); plot = 1'b1;
      exp_fb[2 * 160 + 10 + i] = 3'(i + 1);
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL b2b_busy[%0d]: got %b, expected 0", i, busy); end
      tick();
    end
    plot = 1'b0;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL b2b_busy_end: got %b, expected 0", busy); end
  endtask

  task automatic test_stall();
    bit ok;
    for (int i = 0; i < 10; i++) begin
      tick();
      tests++;
      if (pix_valid !== 1'b1 || pix_x !== 8'd0 || pix_y !== 7'd0 || pix_color !== 3'd0) begin
        fails++;
        $display("FAIL stall_hold[%0d]: got v=%b (%0d,%0d) c=%0d, expected v=1 (0,0) c=0", i, pix_valid, pix_x, pix_y, pix_color);
      end
    end
    pix_ready = 1'b1;
    tick();
    pix_ready = 1'b0;
    tests++; if (pix_valid !== 1'b0) begin fails++; $display("FAIL stall_release_valid: got %b, expected 0", pix_valid); end
    wait_valid(ok);
    repeat (3) tick();
    tests++;
    if (!ok || pix_x !== 8'd1 || pix_y !== 7'd0 || pix_color !== 3'd0 || frame_start !== 1'b0) begin
      fails++;
      $display("FAIL stall_step: got v=%b (%0d,%0d) c=%0d, expected v=1 (1,0) c=0", pix_valid, pix_x, pix_y, pix_color);
    end
  endtask

  task automatic test_frame();
    int idx, bad, bidx, ex, ey;
    bit ok;
    idx = 1; bad = 0; bidx = -1;
    pix_ready = 1'b1;
    for (int k = 0; k < 19200; k++) begin
      wait_valid(ok);
      if (!ok) begin
        bad++;
        bidx = idx;
        break;
      end
      ex = idx % 160;
      ey = idx / 160;
      obs_fb[idx] = pix_color;
      if (pix_x !== 8'(ex) || pix_y !== 7'(ey) || pix_color !== exp_fb[idx] ||
          frame_start !== ((ex == 0 && ey == 0) ? 1'b1 : 1'b0)) begin
        if (bad == 0) bidx = idx;
        bad++;
      end
      tick();
      idx = (idx + 1) % 19200;
    end
    pix_ready = 1'b0;
    tests++; if (bad != 0) begin fails++; $display("FAIL frame_scan: got %0d bad pixels (first idx %0d), expected 0", bad, bidx); end
    tests++; if (obs_fb[11592] !== 3'd5) begin fails++; $display("FAIL px_72_72: got %0d, expected 5", obs_fb[11592]); end
    tests++;
    if (obs_fb[11591] !== 3'd0 || obs_fb[11593] !== 3'd0 || obs_fb[11432] !== 3'd0 || obs_fb[11752] !== 3'd0) begin
      fails++;
      $display("FAIL px_neigh: got %0d %0d %0d %0d, expected 0 0 0 0", obs_fb[11591], obs_fb[11593], obs_fb[11432], obs_fb[11752]);
    end
    tests++; if (obs_fb[5] !== 3'd2) begin fails++; $display("FAIL px_5_0: got %0d, expected 2", obs_fb[5]); end
    tests++; if (obs_fb[160] !== 3'd0) begin fails++; $display("FAIL px_0_1: got %0d, expected 0", obs_fb[160]); end
    for (int i = 0; i < 6; i++) begin
      tests++;
      if (obs_fb[330 + i] !== 3'(i + 1)) begin
        fails++;
        $display("FAIL px_b2b[%0d]: got %0d, expected %0d", i, obs_fb[330 + i], i + 1);
      end
    end
    wait_valid(ok);
    tests++;
    if (!ok || pix_x !== 8'd1 || pix_y !== 7'd0) begin
      fails++;
      $display("FAIL frame_wrap: got v=%b (%0d,%0d), expected v=1 (1,0)", pix_valid, pix_x, pix_y);
    end
  endtask

  task automatic test_reset_mid_run();
    int n, bad;
    bit ok;
    VGA_Y = 7'd0; plot = 1'b1;
    VGA_X = 8'd20; VGA_COLOR = 3'd3; tick();
    VGA_X = 8'd21; VGA_COLOR = 3'd4; tick();
    VGA_X = 8'd22; VGA_COLOR = 3'd6; tick();
    plot = 1'b0;
    Resetn = 1'b0;
    #1;
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL mid_reset_busy: got %b, expected 1", busy); end
    tests++; if (drop !== 1'b0) begin fails++; $display("FAIL mid_reset_drop: got %b, expected 0", drop); end
    tests++;
    if (pix_valid !== 1'b0 || pix_x !== 8'd0 || pix_y !== 7'd0 || pix_color !== 3'd0 || frame_start !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset_scan: got v=%b (%0d,%0d) c=%0d fs=%b, expected v=0 (0,0) c=0 fs=0", pix_valid, pix_x, pix_y, pix_color, frame_start);
    end
    repeat (2) tick();
    Resetn = 1'b1;
    do_plot(8'd3, 7'd3, 3'd7);
    tests++; if (drop !== 1'b1) begin fails++; $display("FAIL clear_plot_drop: got %b, expected 1", drop); end
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL clear_plot_busy: got %b, expected 1", busy); end
    n = 0;
    while (busy === 1'b1 && n < 20000) begin
      tick();
      n++;
    end
    tests++; if (n != 19199) begin fails++; $display("FAIL reclear_len: got %0d more busy cycles, expected 19199", n); end
    pix_ready = 1'b1;
    bad = 0;
    for (int idx = 0; idx < 500; idx++) begin
      wait_valid(ok);
      if (!ok) begin
        bad++;
        break;
      end
      if (pix_x !== 8'(idx % 160) || pix_y !== 7'(idx / 160) || pix_color !== 3'd0) bad++;
      tick();
    end
    pix_ready = 1'b0;
    tests++; if (bad != 0) begin fails++; $display("FAIL post_reset_scan: got %0d bad pixels, expected 0", bad); end
  endtask

  initial begin
    for (int i = 0; i < 19200; i++) begin
      exp_fb[i] = 3'd0;
      obs_fb[i] = 3'd0;
    end
    test_reset();
    test_clear();
    test_plot();
    test_out_of_range();
    test_back_to_back();
    test_stall();
    test_frame();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
